uart_seg_disp: RTL and testbench
================================

UART_SEG_DISP -- requirements
Module: uart_seg_disp

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning clk cycles each digit is driven (1 ms at 50 MHz); legal range 2..2^20.
REQ-002 SHALL have parameter ACT_LEN, default 5000000, meaning clk cycles the activity dot stays lit after a received byte; legal range 1..2^24.
REQ-003 SHALL have port: clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port: res  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port: uart_done  input  1  one-cycle strobe, received byte valid.
REQ-006 SHALL have port: uart_data  input  8  received byte; sampled only when uart_done=1.
REQ-007 SHALL have port: seg_sel  output  6  digit enables; active-low; seg_sel[0] is the rightmost digit.
REQ-008 SHALL have port: seg_led  output  8  segments {dp,g,f,e,d,c,b,a}; active-low.

Function
REQ-009 SHALL hold a 24-bit history register; on uart_done=1, history <= {history[15:0], uart_data}, so the newest byte sits in [7:0].
REQ-010 SHALL keep byte count bcnt (0..3), incremented on each uart_done and saturating at 3.
REQ-011 SHALL map digit k (0..5) to history[4k+3:4k]: digit 0 is the low nibble of the newest byte, digit 5 is the high nibble of the oldest byte.
REQ-012 SHALL treat digit k as valid when k < 2*bcnt; an invalid digit drives seg_led[6:0]=7'h7F (blank).
REQ-013 SHALL encode valid nibbles as seg_led[6:0] (hex, dp excluded): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
REQ-014 SHALL run scan counter scnt from 0 to SCAN_DIV-1 and then wrap to 0; on wrap, digit index idx advances 0,1,2,3,4,5,0,...
REQ-015 SHALL register seg_sel and seg_led: in the cycle after any change to idx, history, bcnt or act, they reflect the new state (1-cycle latency).
REQ-016 SHALL drive exactly one seg_sel bit low at a time after reset: seg_sel = ~(6'b1 << idx).
REQ-017 SHALL run activity counter act: loaded with ACT_LEN on uart_done, otherwise decremented to 0 and held at 0.
REQ-018 SHALL drive seg_led[7]=0 only when idx=0 and act!=0; otherwise seg_led[7]=1.
REQ-019 SHALL apply uart_done and a scan wrap in the same cycle both fully: the shift and the idx advance happen together, and the next registered output uses the new idx and new history.
REQ-020 SHALL reload act to ACT_LEN on a uart_done that arrives while act!=0 (retrigger, no accumulation).
REQ-021 SHALL let history keep shifting after bcnt saturates; the oldest byte is discarded.
REQ-022 SHALL ignore uart_data when uart_done=0.

Reset
REQ-023 SHALL, while res=1, asynchronously force history=0, bcnt=0, scnt=0, idx=0, act=0, seg_sel=6'b111111 and seg_led=8'hFF (all dark).
REQ-024 SHALL, on res asserted mid-scan or mid-activity, abandon the current state with no partial output; after release, the first digit driven is digit 0, blank.
REQ-025 SHALL drive seg_sel=6'b111110 in the first cycle after res deasserts.

Verification (SCAN_DIV=4, ACT_LEN=10)
REQ-026 SHALL cover idle after reset: no uart_done for 48 cycles -> seg_sel walks 3E,3D,3B,37,2F,1F, each held 4 cycles, with seg_led=FF throughout.
REQ-027 SHALL cover single byte 0xA5: digit 0 -> seg_led=92, digit 1 -> seg_led=88, digits 2..5 -> FF; dp low on digit 0 for 10 cycles after the strobe.
REQ-028 SHALL cover four bytes 0x12, 0x34, 0x56, 0x78: digits 5..0 show 3,4,5,6,7,8 (B0,99,92,82,F8,80), with bcnt held at 3.
REQ-029 SHALL cover a strobe coincident with the scan wrap from idx=5: the next cycle has seg_sel=3E and seg_led equal to the encoding of the new byte's low nibble.
REQ-030 SHALL cover a second strobe 6 cycles after the first: dp remains low for 10 cycles counted from the second strobe.
REQ-031 SHALL cover res pulsed for 1 cycle with bcnt=3 and act!=0: outputs go 3F/FF immediately, then 3E/FF, and all digits are blank until the next strobe.

Source files
------------

// File: rtl/uart_seg_disp.sv
// Six-digit multiplexed hex display of the last three UART bytes, newest on the right.
// Outputs are registered from next-state, so a strobe or scan step shows on the following cycle.
module uart_seg_disp #(
  parameter int SCAN_DIV = 50000,
  parameter int ACT_LEN  = 5000000
) (
  input  logic       clk,
  input  logic       res,
  input  logic       uart_done,
  input  logic [7:0] uart_data,
  output logic [5:0] seg_sel,
  output logic [7:0] seg_led
);

  localparam int SW = 20;
  localparam int AW = 25;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [AW-1:0] ACT_INIT  = AW'(ACT_LEN);

  logic [23:0]   history, history_nxt;
  logic [1:0]    bcnt, bcnt_nxt;
  logic [SW-1:0] scnt, scnt_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [AW-1:0] act, act_nxt;
  logic          wrap;
  logic [3:0]    nib;
  logic [6:0]    seg_enc;
  logic          dig_vld;
  logic          dp_n;

  always_comb begin
    wrap     = (scnt == SCAN_LAST);
    scnt_nxt = wrap ? '0 : scnt + SW'(1);
    idx_nxt  = idx;
    if (wrap) idx_nxt = (idx == 3'd5) ? 3'd0 : idx + 3'd1;

    history_nxt = uart_done ? {history[15:0], uart_data} : history;
    bcnt_nxt    = (uart_done && bcnt != 2'd3) ? bcnt + 2'd1 : bcnt;
    // A new strobe reloads rather than extends the activity window.
    if (uart_done)        act_nxt = ACT_INIT;
    else if (act != '0)   act_nxt = act - AW'(1);
    else                  act_nxt = act;
  end

  always_comb begin
    nib = 4'h0;
    case (idx_nxt)
      3'd0:    nib = history_nxt[3:0];
      3'd1:    nib = history_nxt[7:4];
      3'd2:    nib = history_nxt[11:8];
      3'd3:    nib = history_nxt[15:12];
      3'd4:    nib = history_nxt[19:16];
      3'd5:    nib = history_nxt[23:20];
      default: nib = 4'h0;
    endcase

    seg_enc = 7'h7F;
    case (nib)
      4'h0: seg_enc = 7'h40;
      4'h1: seg_enc = 7'h79;
      4'h2: seg_enc = 7'h24;
      4'h3: seg_enc = 7'h30;
      4'h4: seg_enc = 7'h19;
      4'h5: seg_enc = 7'h12;
      4'h6: seg_enc = 7'h02;
      4'h7: seg_enc = 7'h78;
      4'h8: seg_enc = 7'h00;
      4'h9: seg_enc = 7'h10;
      4'hA: seg_enc = 7'h08;
      4'hB: seg_enc = 7'h03;
      4'hC: seg_enc = 7'h46;
      4'hD: seg_enc = 7'h21;
      4'hE: seg_enc = 7'h06;
      4'hF: seg_enc = 7'h0E;
      default: seg_enc = 7'h7F;
    endcase

    // Each received byte lights two digits, so digit k is valid below 2*bcnt.
    dig_vld = (idx_nxt < {bcnt_nxt, 1'b0});
    dp_n    = !((idx_nxt == 3'd0) && (act_nxt != '0));
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      history <= '0;
      bcnt    <= '0;
      scnt    <= '0;
      idx     <= '0;
      act     <= '0;
      seg_sel <= 6'b111111;
      seg_led <= 8'hFF;
    end else begin
      history <= history_nxt;
      bcnt    <= bcnt_nxt;
      scnt    <= scnt_nxt;
      idx     <= idx_nxt;
      act     <= act_nxt;
      seg_sel <= ~(6'b000001 << idx_nxt);
      seg_led <= {dp_n, dig_vld ? seg_enc : 7'h7F};
    end
  end

endmodule

// File: tb/tb_uart_seg_disp.sv
// Directed bench for uart_seg_disp with SCAN_DIV=4, ACT_LEN=10.
module tb_uart_seg_disp;

  logic       clk;
  logic       res;
  logic       uart_done;
  logic [7:0] uart_data;
  logic [5:0] seg_sel;
  logic [7:0] seg_led;

  int tests = 0;
  int fails = 0;
  int n = 0;
  int last_strobe = -1000;

  uart_seg_disp #(.SCAN_DIV(4), .ACT_LEN(10)) dut (
    .clk       (clk),
    .res       (res),
    .uart_done (uart_done),
    .uart_data (uart_data),
    .seg_sel   (seg_sel),
    .seg_led   (seg_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          nb;
    logic [39:0] bytes;  // byte i sent i-th, at [8i+7:8i]
    logic [47:0] exp;    // seg_led for digit k at [8k+7:8k], dp dark
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [13:0] got, input logic [13:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at n=%0d: got sel/led %h, expected %h", name, n, got, exp);
    end
  endtask

  function automatic logic [5:0] exp_sel(input int k);
    logic [5:0] one;
    one = 6'b000001;
    return ~(one << ((k / 4) % 6));
  endfunction

  function automatic logic exp_dp(input int k);
    return !(((k / 4) % 6 == 0) && (k - last_strobe < 10));
  endfunction

  task automatic tick(input logic d, input logic [7:0] dat);
    uart_done = d;
    uart_data = dat;
    @(posedge clk);
    n++;
    if (d) last_strobe = n;
    @(negedge clk);
    uart_done = 1'b0;
    uart_data = 8'($urandom);
  endtask

  task automatic do_reset();
    res = 1'b1;
    #1;
    chk("rst_async", {seg_sel, seg_led}, {6'h3F, 8'hFF});
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold", {seg_sel, seg_led}, {6'h3F, 8'hFF});
    res = 1'b0;
    n = 0;
    last_strobe = -1000;
    tick(1'b0, 8'($urandom));
    chk("first_after_rst", {seg_sel, seg_led}, {6'h3E, 8'hFF});
  endtask

  task automatic check_scan(input string name, input logic [47:0] exp);
    for (int c = 0; c < 24; c++) begin
      tick(1'b0, 8'($urandom));
      chk(name, {seg_sel, seg_led}, {exp_sel(n), exp[8 * ((n / 4) % 6) +: 8]});
    end
  endtask

  initial begin
    res = 1'b1;
    uart_done = 1'b0;
    uart_data = 8'h00;

    vecs[0] = '{0, 40'h0,              48'hFF_FF_FF_FF_FF_FF};
    vecs[1] = '{1, 40'hA5,             48'hFF_FF_FF_FF_88_92};
    vecs[2] = '{4, 40'h00_78_56_34_12, 48'hB0_99_92_82_F8_80};
    vecs[3] = '{2, 40'h9C_F0,          48'hFF_FF_8E_C0_90_C6};
    vecs[4] = '{3, 40'h00_B7_DE,       48'hA1_86_83_F8_C0_C0};
    vecs[5] = '{5, 40'h5A_44_33_22_11, 48'hB0_B0_99_99_92_88};
    vecs[6] = '{1, 40'h12,             48'hFF_FF_FF_FF_F9_A4};
    vecs[7] = '{2, 40'hE1_68,          48'hFF_FF_82_80_86_F9};

    @(negedge clk);

    // Idle walk after reset: digits blank, one enable low, 4 cycles per digit.
    do_reset();
    for (int c = 0; c < 48; c++) begin
      tick(1'b0, 8'($urandom));
      chk("idle_walk", {seg_sel, seg_led}, {exp_sel(n), 8'hFF});
    end

    // Table: back-to-back strobes, let activity expire, then scan all digits.
    for (int v = 0; v < 8; v++) begin
      do_reset();
      for (int b = 0; b < vecs[v].nb; b++) tick(1'b1, vecs[v].bytes[8 * b +: 8]);
      for (int c = 0; c < 12; c++) tick(1'b0, 8'($urandom));
      check_scan($sformatf("vec%0d", v), vecs[v].exp);
    end

    // Activity dot retriggered 6 cycles after the first strobe.
    do_reset();
    while (n < 9) tick(1'b0, 8'($urandom));
    tick(1'b1, 8'h3C);
    while (n < 15) tick(1'b0, 8'($urandom));
    tick(1'b1, 8'h3C);
    while (n < 30) begin
      tick(1'b0, 8'($urandom));
      chk("dp_retrig", {seg_sel, 7'h0, seg_led[7]}, {exp_sel(n), 7'h0, exp_dp(n)});
    end

    // Strobe landing on the wrap from digit 5 to digit 0.
    do_reset();
    while (n < 23) tick(1'b0, 8'($urandom));
    tick(1'b1, 8'h4B);
    chk("wrap_strobe", {seg_sel, seg_led}, {6'h3E, 8'h03});
    while (n < 28) tick(1'b0, 8'($urandom));
    chk("wrap_strobe_d1", {seg_sel, seg_led}, {6'h3D, 8'h99});

    // Reset mid-activity with a full history.
    do_reset();
    tick(1'b1, 8'h12);
    tick(1'b1, 8'h34);
    tick(1'b1, 8'h56);
    tick(1'b1, 8'h78);
    tick(1'b0, 8'($urandom));
    do_reset();
    check_scan("post_rst_blank", 48'hFF_FF_FF_FF_FF_FF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
